// File: rtl/fifo_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : fifo_pkg
//  Brief    : Shared FIFO helpers: address-width function and error record.
//  Revision : 1.0 - initial release
// =============================================================================
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// =============================================================================
//  Module   : fifo_ram
//  Brief    : FIFO storage, one synchronous write port, one asynchronous read.
//  Revision : 1.0 - initial release
// =============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW   = fifo_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are intentionally not reset so this maps onto distributed RAM.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// =============================================================================
//  Module   : sync_fifo_flags
//  Brief    : Single-clock FIFO with threshold flags, sticky errors and FWFT.
//  Revision : 1.0 - initial release
// =============================================================================
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0,
    localparam int AW       = fifo_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear_err,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_afull_th  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] c_aempty_th = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] c_ptr_one   = (AW+1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("sync_fifo_flags: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
        $error("sync_fifo_flags: AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
        $error("sync_fifo_flags: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      w_count;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_head;
    fifo_err_t        r_err;

    // The extra wrap bit lets full and empty be told apart by plain subtraction.
    assign w_count = r_wptr - r_rptr;

    assign full         = (w_count == c_depth);
    assign empty        = (w_count == '0);
    assign almost_full  = (w_count >= c_afull_th);
    assign almost_empty = (w_count <= c_aempty_th);
    assign count        = w_count;

    // A pop in the same cycle frees the slot, so a write to a full FIFO can proceed.
    assign w_rd_ok = ren && !empty;
    assign w_wr_ok = wen && (!full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    // Later assignments win, so an error in the clearing cycle stays set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            if (clear_err) begin
                r_err <= '0;
            end
            if (wen && !w_wr_ok) begin
                r_err.overflow <= 1'b1;
            end
            if (ren && !w_rd_ok) begin
                r_err.underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_err.overflow;
    assign underflow = r_err.underflow;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_ok),
        .waddr (r_wptr[AW-1:0]),
        .wdata (wdata),
        .raddr (r_rptr[AW-1:0]),
        .rdata (w_head)
    );

    if (FWFT != 0) begin : g_fwft
        assign rdata = w_head;
    end else begin : g_std
        logic [WIDTH-1:0] r_rdata;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (w_rd_ok) begin
                r_rdata <= w_head;
            end
        end

        assign rdata = r_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// =============================================================================
//  Module   : tb_sync_fifo_flags
//  Brief    : Self-checking bench for sync_fifo_flags (standard and FWFT).
//  Revision : 1.0 - initial release
// =============================================================================
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] wdata;
    logic       wen, ren, clear_err;
    logic [3:0] rdata;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic [3:0] f_wdata;
    logic       f_wen, f_ren, f_clear_err;
    logic [3:0] f_rdata;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0] f_count;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [3:0] sb[$];
    logic       m_ovf, m_unf;
    logic [3:0] exp_rd;
    logic       popped;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)
    ) dut (
        .clk(clk), .reset(reset), .wdata(wdata), .wen(wen), .ren(ren),
        .clear_err(clear_err), .rdata(rdata), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(
        .WIDTH(4), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .reset(reset), .wdata(f_wdata), .wen(f_wen), .ren(f_ren),
        .clear_err(f_clear_err), .rdata(f_rdata), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // Drives one cycle on the standard instance and advances the reference queue.
    task automatic drive(input logic w, input logic [3:0] d, input logic r, input logic clr);
        logic rd_ok, wr_ok;
        rd_ok = r && (sb.size() != 0);
        wr_ok = w && (sb.size() != 8 || rd_ok);
        wen = w; wdata = d; ren = r; clear_err = clr;
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (w && !wr_ok) m_ovf = 1'b1;
        if (r && !rd_ok) m_unf = 1'b1;
        popped = rd_ok;
        if (rd_ok) exp_rd = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        @(posedge clk); #1;
        wen = 1'b0; ren = 1'b0; clear_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_checks++; if (almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_aempty: got %b expected 1", almost_empty); end
        n_checks++; if (count !== 4'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got full=%b afull=%b expected 0 0", full, almost_full); end
        n_checks++; if (rdata !== 4'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_errors++; $display("FAIL reset_err: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
        n_checks++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin n_errors++; $display("FAIL reset_fwft: got empty=%b count=%0d expected 1 0", f_empty, f_count); end
        reset = 1'b0;
        sb.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_errors++; $display("FAIL idle_after_reset: got empty=%b count=%0d expected 1 0", empty, count); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'(i), 1'b0, 1'b0);
            n_checks++; if (count !== 4'(i)) begin n_errors++; $display("FAIL fill_count: got %0d expected %0d", count, i); end
            n_checks++; if (almost_full !== 1'(i >= 6)) begin n_errors++; $display("FAIL fill_afull: got %b expected %b at count %0d", almost_full, i >= 6, i); end
            n_checks++; if (full !== 1'(i == 8)) begin n_errors++; $display("FAIL fill_full: got %b expected %b at count %0d", full, i == 8, i); end
            n_checks++; if (almost_empty !== 1'(i <= 2)) begin n_errors++; $display("FAIL fill_aempty: got %b expected %b at count %0d", almost_empty, i <= 2, i); end
        end
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        n_checks++; if (overflow !== m_ovf) begin n_errors++; $display("FAIL overflow_set: got %b expected %b", overflow, m_ovf); end
        n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL overflow_count: got %0d expected 8", count); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0);
            n_checks++; if (!popped || rdata !== exp_rd) begin n_errors++; $display("FAIL drain_data: got %h expected %h", rdata, exp_rd); end
            n_checks++; if (count !== 4'(sb.size())) begin n_errors++; $display("FAIL drain_count: got %0d expected %0d", count, sb.size()); end
        end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        n_checks++; if (rdata !== 4'h8) begin n_errors++; $display("FAIL hold_rdata: got %h expected 8", rdata); end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_full_rw();
        logic [3:0] last;
        for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        drive(1'b1, 4'hA, 1'b1, 1'b0);
        n_checks++; if (count !== 4'd8) begin n_errors++; $display("FAIL full_rw_count: got %0d expected 8", count); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL full_rw_ovf: got %b expected 0", overflow); end
        n_checks++; if (rdata !== exp_rd) begin n_errors++; $display("FAIL full_rw_data: got %h expected %h", rdata, exp_rd); end
        last = 4'h0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0);
            n_checks++; if (rdata !== exp_rd) begin n_errors++; $display("FAIL full_rw_drain: got %h expected %h", rdata, exp_rd); end
            last = rdata;
        end
        n_checks++; if (last !== 4'hA) begin n_errors++; $display("FAIL full_rw_last: got %h expected a", last); end
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 4'h3, 1'b1, 1'b0);
        n_checks++; if (underflow !== 1'b1) begin n_errors++; $display("FAIL empty_rw_unf: got %b expected 1", underflow); end
        n_checks++; if (count !== 4'd1) begin n_errors++; $display("FAIL empty_rw_count: got %0d expected 1", count); end
        n_checks++; if (rdata !== 4'hA) begin n_errors++; $display("FAIL empty_rw_hold: got %h expected a", rdata); end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL clear_unf: got %b expected 0", underflow); end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        n_checks++; if (rdata !== exp_rd || empty !== 1'b1) begin n_errors++; $display("FAIL empty_rw_pop: got %h empty=%b expected %h empty=1", rdata, empty, exp_rd); end
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        n_checks++; if (underflow !== m_unf) begin n_errors++; $display("FAIL set_beats_clear: got %b expected %b", underflow, m_unf); end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        n_checks++; if (underflow !== 1'b0) begin n_errors++; $display("FAIL clear_again: got %b expected 0", underflow); end
    endtask

    task automatic test_fwft();
        f_wen = 1'b1; f_wdata = 4'h5; f_ren = 1'b0;
        @(posedge clk); #1;
        f_wen = 1'b0;
        n_checks++; if (f_rdata !== 4'h5) begin n_errors++; $display("FAIL fwft_visible: got %h expected 5", f_rdata); end
        n_checks++; if (f_empty !== 1'b0 || f_count !== 4'd1) begin n_errors++; $display("FAIL fwft_count: got empty=%b count=%0d expected 0 1", f_empty, f_count); end
        @(posedge clk); #1;
        n_checks++; if (f_rdata !== 4'h5) begin n_errors++; $display("FAIL fwft_hold: got %h expected 5", f_rdata); end
        f_ren = 1'b1;
        @(posedge clk); #1;
        f_ren = 1'b0;
        n_checks++; if (f_empty !== 1'b1 || f_underflow !== 1'b0) begin n_errors++; $display("FAIL fwft_pop: got empty=%b unf=%b expected 1 0", f_empty, f_underflow); end
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 4'(i + 11), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            n_checks++; if (rdata !== exp_rd) begin n_errors++; $display("FAIL wrap_data: got %h expected %h", rdata, exp_rd); end
            n_checks++; if (count !== 4'd3) begin n_errors++; $display("FAIL wrap_count: got %0d expected 3", count); end
        end
        drive(1'b1, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd5) begin n_errors++; $display("FAIL pre_reset_count: got %0d expected 5", count); end
        do_reset();
        n_checks++; if (count !== 4'd0 || empty !== 1'b1) begin n_errors++; $display("FAIL mid_reset: got count=%0d empty=%b expected 0 1", count, empty); end
    endtask

    initial begin
        reset = 1'b1; wen = 1'b0; ren = 1'b0; clear_err = 1'b0; wdata = 4'h0;
        f_wen = 1'b0; f_ren = 1'b0; f_clear_err = 1'b0; f_wdata = 4'h0;
        m_ovf = 1'b0; m_unf = 1'b0; exp_rd = 4'h0; popped = 1'b0;
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_fwft();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
